mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_CORES, default 4: number of SM cores sharing global memory; range 2..16.
REQ-002 Parameter ADDR_W, default 8: memory address width.
REQ-003 Parameter DATA_W, default 16: memory data width.
REQ-004 Parameter MEM_TIMEOUT, default 255: watchdog limit in cycles; used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 core_mread  in  N_CORES  per-core one-cycle read request pulse (CU MRead).
REQ-008 core_mwrite  in  N_CORES  per-core one-cycle write request pulse (CU MWrite).
REQ-009 core_addr  in  N_CORES*ADDR_W  per-core address, slice i = core i; held stable by the core until its core_mready.
REQ-010 core_wdata  in  N_CORES*DATA_W  per-core write data; held stable like core_addr.
REQ-011 core_mready  out  N_CORES  one-cycle completion pulse to the granted core (CU MReady).
REQ-012 core_rdata  out  DATA_W  shared read data; valid only in the core_mready cycle.
REQ-013 core_err  out  1  high with core_mready when the access timed out.
REQ-014 mem_read, mem_write  out  1 each  level request to memory, held until mem_ready.
REQ-015 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W: granted core's slices.
REQ-016 mem_rdata  in  DATA_W; mem_ready  in  1: memory completion, one cycle.

Function
REQ-017 Pending register, N_CORES bits plus a per-core write flag: a pulse on core_mread[i] or core_mwrite[i] SHALL set pending[i] at the next edge.
REQ-018 A pulse for a core already pending SHALL be ignored (one outstanding access per core).
REQ-019 core_mread[i] and core_mwrite[i] in the same cycle SHALL be latched as a write; the read is dropped.
REQ-020 FSM states IDLE, BUSY, RESP; IDLE after reset.
REQ-021 IDLE: if any pending bit is set, grant the first pending core searching round-robin from rr_ptr+1 (mod N_CORES), register the grant index, go to BUSY; otherwise stay.
REQ-022 BUSY: mem_read or mem_write (per write flag) high, mem_addr/mem_wdata from granted slices; on mem_ready capture mem_rdata and go to RESP.
REQ-023 RESP: core_mready[grant]=1 for exactly one cycle, core_rdata = captured data (0 for writes), clear pending[grant], rr_ptr <= grant, go to IDLE.
REQ-024 mem_read/mem_write SHALL be low in IDLE and RESP; at most one of them high at any time.
REQ-025 Minimum latency with zero-wait memory: pulse at cycle 0 -> mem request cycle 2 -> core_mready cycle 3.
REQ-026 A new pulse from any core (including the one being answered in RESP) SHALL be latched in parallel with FSM activity and never lost.
REQ-027 Starvation bound: a pending core SHALL be granted within N_CORES-1 other grants.
REQ-028 core_mready SHALL be one-hot or zero.

Reset
REQ-029 On reset: state IDLE, pending and write flags 0, rr_ptr = N_CORES-1 (core 0 first), grant 0, watchdog 0.
REQ-030 During reset all outputs SHALL be 0, including mid-access; an aborted access is not answered.

Configuration
REQ-031 Macro MEM_ARB_TIMEOUT_EN defined: watchdog counts BUSY cycles; when it reaches MEM_TIMEOUT without mem_ready, drop the memory request, go to RESP with core_err=1 and core_rdata=0; counter clears on entry to BUSY.
REQ-032 Macro absent: no counter; BUSY waits indefinitely; core_err tied 0.

Structure
REQ-033 Shared package/header: FSM state encodings and the default N_CORES, ADDR_W and DATA_W constants.
REQ-034 One sub-module rr_picker (combinational round-robin select: pending vector, pointer -> index, valid).

Verification
REQ-035 Single read: core 2 mread, addr 0x10, mem_ready on first BUSY cycle, mem_rdata 0x1234 -> core_mready=0b0100 at cycle 3, core_rdata 0x1234.
REQ-036 Fairness: all 4 cores pulse mread in cycle 0 after reset -> grants in order 0,1,2,3, each core_mready exactly once.
REQ-037 Re-request in RESP: core 1 pulses again in its own core_mready cycle while core 3 is pending -> core 3 served next, then core 1.
REQ-038 Read+write collision: core 0 pulses both, wdata 0xBEEF -> only mem_write=1 with mem_wdata 0xBEEF; core_rdata 0.
REQ-039 Timeout (macro on, MEM_TIMEOUT=8): mem_ready never asserted -> after 8 BUSY cycles core_mready with core_err=1 and mem_read drops; macro off -> request held for 100 cycles with no core_mready.
REQ-040 Reset mid-BUSY: assert reset for 1 cycle -> all outputs 0 next cycle, pending cleared, next request serviced normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and FSM encoding for the round-robin global-memory arbiter.
package mem_arbiter_pkg;

    localparam int N_CORES_DEF = 4;
    localparam int ADDR_W_DEF  = 8;
    localparam int DATA_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin select: first set bit of pending searching upward from ptr+1.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         pending,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int IW = $clog2(N);

    // Walk from farthest to nearest so the closest candidate after ptr wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int k = N; k >= 1; k--) begin
            if (pending[(int'(ptr) + k) % N]) begin
                idx   = IW'((int'(ptr) + k) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter letting N_CORES cores share one global memory port.
// Optional BUSY watchdog is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int N_CORES     = N_CORES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        core_mread,
    input  logic [N_CORES-1:0]        core_mwrite,
    input  logic [N_CORES*ADDR_W-1:0] core_addr,
    input  logic [N_CORES*DATA_W-1:0] core_wdata,
    output logic [N_CORES-1:0]        core_mready,
    output logic [DATA_W-1:0]         core_rdata,
    output logic                      core_err,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    input  logic                      mem_ready
);
    localparam int IW = $clog2(N_CORES);

    if (N_CORES < 2 || N_CORES > 16) begin : g_bad_n_cores
        $error("mem_arbiter: N_CORES must be in 2..16");
    end
    if (MEM_TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: MEM_TIMEOUT must be at least 1");
    end

    arb_state_e          state, state_nx;
    logic [N_CORES-1:0]  pending, wr_flag, resp_clr;
    logic [IW-1:0]       rr_ptr, grant, pick_idx;
    logic                pick_valid;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                timeout;

    rr_picker #(.N(N_CORES)) u_picker (
        .pending (pending),
        .ptr     (rr_ptr),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    always_comb begin
        resp_clr = '0;
        if (state == ST_RESP) resp_clr[grant] = 1'b1;
    end

    // A core being answered this cycle may already post its next request.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
            wr_flag <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (pending[i] && !resp_clr[i]) begin
                    pending[i] <= 1'b1;
                end else if (core_mread[i] || core_mwrite[i]) begin
                    pending[i] <= 1'b1;
                    wr_flag[i] <= core_mwrite[i];
                end else begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != ST_BUSY) wd_cnt <= '0;
        else if (!mem_ready)           wd_cnt <= wd_cnt + 1'b1;
    end

    assign timeout = (state == ST_BUSY) && !mem_ready && (wd_cnt == WD_W'(MEM_TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            rr_ptr  <= IW'(N_CORES - 1);
            grant   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick_idx;
                        err_q <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mem_ready) begin
                        rdata_q <= wr_flag[grant] ? '0 : mem_rdata;
                    end else if (timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ST_RESP: rr_ptr <= grant;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (pick_valid)            state_nx = ST_BUSY;
            ST_BUSY: if (mem_ready || timeout)  state_nx = ST_RESP;
            ST_RESP:                            state_nx = ST_IDLE;
            default:                            state_nx = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even mid-access.
    always_comb begin
        core_mready = '0;
        core_rdata  = '0;
        core_err    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (!reset) begin
            case (state)
                ST_BUSY: begin
                    mem_read  = !wr_flag[grant];
                    mem_write = wr_flag[grant];
                    mem_addr  = core_addr[int'(grant)*ADDR_W +: ADDR_W];
                    mem_wdata = core_wdata[int'(grant)*DATA_W +: DATA_W];
                end
                ST_RESP: begin
                    core_mready[grant] = 1'b1;
                    core_rdata         = rdata_q;
                    core_err           = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences, random traffic vs model.
module tb_mem_arbiter;
    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      core_mread = '0, core_mwrite = '0;
    logic [N*AW-1:0]   core_addr = '0;
    logic [N*DW-1:0]   core_wdata = '0;
    logic [N-1:0]      core_mready;
    logic [DW-1:0]     core_rdata;
    logic              core_err, mem_read, mem_write;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              mem_ready = 1'b0;

    mem_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .core_mread(core_mread), .core_mwrite(core_mwrite),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_mready(core_mready), .core_rdata(core_rdata), .core_err(core_err),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int order[$];

    typedef struct {
        int          core;
        bit          rd, wr;
        logic [7:0]  addr;
        logic [15:0] wdata, mdata;
        int          lat;
        bit          exp_rd, exp_wr;
        logic [15:0] exp_rdata;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs_or();
        return {25'd0, |core_mready, core_err, mem_read, mem_write,
                |core_rdata, |mem_addr, |mem_wdata};
    endfunction

    task automatic idle_inputs();
        core_mread = '0; core_mwrite = '0; mem_ready = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1; idle_inputs();
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic access(input vec_t v);
        @(posedge clk); #1;
        core_addr[v.core*AW +: AW]  = v.addr;
        core_wdata[v.core*DW +: DW] = v.wdata;
        core_mread[v.core]  = v.rd;
        core_mwrite[v.core] = v.wr;
        @(posedge clk); #1; core_mread = '0; core_mwrite = '0;
        @(negedge clk); chk("vec_no_req_cycle1", {mem_read, mem_write}, 0);
        @(posedge clk); #1; mem_ready = (v.lat == 0); mem_rdata = v.mdata;
        @(negedge clk);
        chk("vec_mem_read", mem_read, v.exp_rd);
        chk("vec_mem_write", mem_write, v.exp_wr);
        chk("vec_mem_addr", mem_addr, v.addr);
        if (v.exp_wr) chk("vec_mem_wdata", mem_wdata, v.wdata);
        for (int k = 0; k < v.lat; k++) begin
            @(posedge clk); #1; mem_ready = (k == v.lat - 1);
            @(negedge clk); chk("vec_req_held", mem_read | mem_write, 1);
        end
        @(posedge clk); #1; mem_ready = 1'b0;
        @(negedge clk);
        chk("vec_mready", core_mready, 32'(1 << v.core));
        chk("vec_rdata", core_rdata, v.exp_rdata);
        chk("vec_err", core_err, 0);
        chk("vec_req_low_resp", {mem_read, mem_write}, 0);
        @(posedge clk); #1;
        @(negedge clk); chk("vec_mready_single", core_mready, 0);
    endtask

    // Zero-wait memory; optionally re-pulses one core in its own answer cycle.
    task automatic run_auto(input string tag, input int cycles, input int rep_core);
        bit reposted = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            core_mread = '0; core_mwrite = '0;
            mem_ready = mem_read | mem_write;
            mem_rdata = 16'hA000 + 16'(mem_addr);
            @(negedge clk);
            if (core_mready != 0) begin
                chk({tag, "_onehot"}, $countones(core_mready), 1);
                for (int i = 0; i < N; i++)
                    if (core_mready[i]) begin
                        order.push_back(i);
                        chk({tag, "_rdata"}, core_rdata, 16'hA000 + 16'(core_addr[i*AW +: AW]));
                    end
                if (rep_core >= 0 && core_mready[rep_core] && !reposted) begin
                    reposted = 1;
                    core_mread[rep_core] = 1'b1;
                end
            end
        end
    endtask

    function automatic int pick(input bit p[N], input int last);
        for (int k = 1; k <= N; k++)
            if (p[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got hung expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int busy, got, cnt;
        bit cur_pend[N], prev_pend[N], m_wr[N];
        logic [AW-1:0] m_addr[N];
        logic [DW-1:0] m_wdata[N];
        logic [DW-1:0] exp_rd;
        int waited[N];
        int m_last, m_grant, busy_cnt;
        bit prev_req, g_wr, pulse_en;

        vecs[0] = '{2, 1, 0, 8'h10, 16'h0000, 16'h1234, 0, 1, 0, 16'h1234};
        vecs[1] = '{0, 1, 1, 8'h20, 16'hBEEF, 16'h7777, 0, 0, 1, 16'h0000};
        vecs[2] = '{3, 0, 1, 8'hFF, 16'h5A5A, 16'h1111, 2, 0, 1, 16'h0000};
        vecs[3] = '{1, 1, 0, 8'h00, 16'h0000, 16'hFFFF, 1, 1, 0, 16'hFFFF};
        vecs[4] = '{0, 1, 0, 8'h80, 16'h0000, 16'h0001, 0, 1, 0, 16'h0001};

        // Reset state, with stray pulses during reset that must not be latched
        @(posedge clk); #1; core_mread = 4'b1111;
        @(negedge clk); chk("reset_outputs", outs_or(), 0);
        @(posedge clk); #1; reset = 1'b0; core_mread = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); chk("post_reset_idle", outs_or(), 0);
            @(posedge clk); #1;
        end

        foreach (vecs[i]) access(vecs[i]);

        // All four cores at once: core 0 first, then rotation
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) core_addr[i*AW +: AW] = 8'(8'h11 * i);
        core_mread = 4'b1111;
        order.delete();
        run_auto("fair", 40, -1);
        chk("fair_count", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) chk("fair_order", order[i], i);

        // Core 1 re-requests while being answered; core 3 must go first
        do_reset();
        @(posedge clk); #1; core_mread = 4'b1010;
        order.delete();
        run_auto("rerq", 40, 1);
        chk("rerq_count", order.size(), 3);
        if (order.size() == 3) begin
            chk("rerq_first", order[0], 1);
            chk("rerq_second", order[1], 3);
            chk("rerq_third", order[2], 1);
        end

        // Memory that never answers
        do_reset();
        @(posedge clk); #1; core_addr[0 +: AW] = 8'h42; core_mread = 4'b0001;
        @(posedge clk); #1; core_mread = '0;
        busy = 0; got = 0;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk);
            if (mem_read) busy++;
            if (core_mready != 0 && got == 0) begin
                got = 1;
                chk("tmo_mready", core_mready, 1);
                chk("tmo_err", core_err, 1);
                chk("tmo_rdata", core_rdata, 0);
                chk("tmo_req_dropped", mem_read, 0);
            end
            @(posedge clk); #1;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        chk("tmo_busy_cycles", busy, 8);
        chk("tmo_answered", got, 1);
`else
        chk("hold_busy_cycles", busy >= 100, 1);
        chk("hold_no_answer", got, 0);
`endif

        // Reset during BUSY aborts the access without an answer
        do_reset();
        @(posedge clk); #1; core_addr[2*AW +: AW] = 8'h33; core_mread = 4'b0100;
        @(posedge clk); #1; core_mread = '0;
        @(posedge clk); #1;
        @(negedge clk); chk("midrst_busy", mem_read, 1);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk); chk("midrst_during", outs_or(), 0);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk); chk("midrst_after", outs_or(), 0);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk); if (outs_or() != 0) cnt++;
        end
        chk("midrst_pending_cleared", cnt, 0);
        access(vecs[3]);

        // Random traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < N; i++) begin
            cur_pend[i] = 0; prev_pend[i] = 0; waited[i] = 0; m_wr[i] = 0;
            m_addr[i] = '0; m_wdata[i] = '0;
        end
        m_last = N - 1; m_grant = -1; prev_req = 0; g_wr = 0; exp_rd = '0; busy_cnt = 0;
        pulse_en = 1;
        for (int c = 0; c < 1700; c++) begin
            if (c == 1500) pulse_en = 0;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                int r;
                if (!cur_pend[i] || core_mready[i]) begin
                    core_addr[i*AW +: AW]  = AW'($urandom);
                    core_wdata[i*DW +: DW] = DW'($urandom);
                end
                r = pulse_en ? int'($urandom_range(0, 7)) : 7;
                core_mread[i]  = (r == 0 || r == 2);
                core_mwrite[i] = (r == 1 || r == 2);
            end
            if (mem_read | mem_write) begin
                busy_cnt++;
                mem_ready = ($urandom_range(0, 1) == 1) || busy_cnt >= 3;
            end else begin
                busy_cnt = 0;
                mem_ready = 1'b0;
            end
            mem_rdata = DW'($urandom);

            @(negedge clk);
            chk("rnd_excl", mem_read & mem_write, 0);
            if ((mem_read | mem_write) && !prev_req) begin
                int g;
                g = pick(prev_pend, m_last);
                chk("rnd_grant_valid", g >= 0, 1);
                if (g >= 0) begin
                    m_grant = g;
                    g_wr = m_wr[g];
                    chk("rnd_rw", {mem_read, mem_write}, g_wr ? 2'b01 : 2'b10);
                    chk("rnd_addr", mem_addr, m_addr[g]);
                    if (g_wr) chk("rnd_wdata", mem_wdata, m_wdata[g]);
                end
            end
            if ((mem_read | mem_write) && mem_ready) exp_rd = g_wr ? '0 : mem_rdata;
            if (core_mready != 0) begin
                chk("rnd_mready", core_mready, (m_grant >= 0) ? 32'(1 << m_grant) : 32'hFFFF_FFFF);
                chk("rnd_rdata", core_rdata, exp_rd);
                chk("rnd_err", core_err, 0);
                if (m_grant >= 0) begin
                    chk("rnd_starvation", waited[m_grant] <= N - 1, 1);
                    for (int i = 0; i < N; i++) if (cur_pend[i] && i != m_grant) waited[i]++;
                    m_last = m_grant;
                end
            end
            prev_req = mem_read | mem_write;
            prev_pend = cur_pend;
            for (int i = 0; i < N; i++) begin
                bit keep;
                keep = cur_pend[i] && !(core_mready != 0 && i == m_grant);
                if (!keep && (core_mread[i] || core_mwrite[i])) begin
                    cur_pend[i] = 1;
                    m_wr[i] = core_mwrite[i];
                    m_addr[i] = core_addr[i*AW +: AW];
                    m_wdata[i] = core_wdata[i*DW +: DW];
                    waited[i] = 0;
                end else begin
                    cur_pend[i] = keep;
                end
            end
        end
        cnt = 0;
        for (int i = 0; i < N; i++) if (cur_pend[i]) cnt++;
        chk("rnd_drained", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
